// File: rtl/cov_pkg.sv
// Shared types and index helpers for the covariance accumulator.
package cov_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Number of upper-triangle pairs (i<=j) for n channels.
    function automatic int npair(input int n);
        return (n * (n + 1)) / 2;
    endfunction

    // Row-major upper-triangle index of pair (i,j), i<=j, for n channels.
    function automatic int pair_idx(input int n, input int i, input int j);
        return (i * n) - ((i * (i - 1)) / 2) + (j - i);
    endfunction

endpackage

// File: rtl/cov_mac_lane.sv
// One product/accumulate lane: registered x_i*x_j, then summed into a wide accumulator.
module cov_mac_lane #(
    parameter int DW = 26,
    parameter int AW = 59,
    parameter int SH = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 add_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic signed [AW-1:0] acc_o
);

    logic signed [2*DW-1:0] a_ext;
    logic signed [2*DW-1:0] b_ext;
    logic signed [2*DW-1:0] prod_d;
    logic signed [2*DW-1:0] prod_q;
    logic signed [AW-1:0]   acc_d;
    logic signed [AW-1:0]   acc_q;

    // Extend before multiplying so (-2^(DW-1))^2 lands exactly in 2*DW bits.
    assign a_ext  = {{DW{a_i[DW-1]}}, a_i};
    assign b_ext  = {{DW{b_i[DW-1]}}, b_i};
    assign prod_d = a_ext * b_ext;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + AW'(prod_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            if (en_i) begin
                prod_q <= prod_d;
            end
            acc_q <= acc_d;
        end
    end

    // SH is zero unless mean scaling is built in.
    assign acc_o = acc_q >>> SH;

endmodule

// File: rtl/cov_accum.sv
// Covariance accumulator: sums all upper-triangle products over N_SAMP samples.
// Build option COV_MEAN_SCALE_EN presents the mean product instead of the raw sum.
module cov_accum
    import cov_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DW     = 26,
    parameter  int N_SAMP = 128,
    localparam int CW     = $clog2(N_SAMP + 1),
    localparam int NPAIR  = npair(N_CH),
    localparam int AW     = 2 * DW + $clog2(N_SAMP)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*DW-1:0]    xcen,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NPAIR*AW-1:0]   cov,
    output logic                  busy
);

`ifdef COV_MEAN_SCALE_EN
    localparam int SH = $clog2(N_SAMP);
    if ((1 << SH) != N_SAMP) begin : g_pow2_chk
        $error("cov_accum: mean scaling requires N_SAMP to be a power of two");
    end
`else
    localparam int SH = 0;
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            v1_q;
    logic            accept;
    logic            clr;

    // Handshakes: a beat transfers on in_valid&in_ready; the result transfers on out_valid&out_ready.
    assign accept = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr       = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(N_SAMP - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last product is still in stage 1 until v1_q drops.
                if (!v1_q) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v1_q    <= accept;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_row
        for (genvar gj = gi; gj < N_CH; gj++) begin : g_col
            localparam int K = pair_idx(N_CH, gi, gj);
            cov_mac_lane #(
                .DW (DW),
                .AW (AW),
                .SH (SH)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .clr_i (clr),
                .en_i  (accept),
                .add_i (v1_q),
                .a_i   (xcen[gi*DW +: DW]),
                .b_i   (xcen[gj*DW +: DW]),
                .acc_o (cov[K*AW +: AW])
            );
        end
    end

endmodule

// File: tb/tb_cov_accum.sv
// Directed bench for cov_accum with hand-computed covariance sums.
module tb_cov_accum;

  localparam int N_CH   = 4;
  localparam int DW     = 26;
  localparam int N_SAMP = 128;
  localparam int NPAIR  = 10;
  localparam int AW     = 59;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [N_CH*DW-1:0]    xcen;
  logic                  out_valid;
  logic                  out_ready;
  logic [NPAIR*AW-1:0]   cov;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef longint vec_t [NPAIR];

  // Hand-computed sums over 128 beats, row-major pair order.
  localparam vec_t EXP_ONES = '{128, 128, 128, 128, 128, 128, 128, 128, 128, 128};
  localparam vec_t EXP_MIX  = '{1152, -768, 0, 1920, 512, 0, -1280, 0, 0, 3200};
  localparam vec_t EXP_EXT  = '{64'sh0200_0000_0000_0000, 64'sh0200_0000_0000_0000,
                                64'sh0200_0000_0000_0000, 64'sh0200_0000_0000_0000,
                                64'sh0200_0000_0000_0000, 64'sh0200_0000_0000_0000,
                                64'sh0200_0000_0000_0000, 64'sh0200_0000_0000_0000,
                                64'sh0200_0000_0000_0000, 64'sh0200_0000_0000_0000};
  localparam vec_t EXP_1234 = '{128, 256, 384, 512, 512, 768, 1024, 1152, 1536, 2048};

  always #5 clk = ~clk;

  cov_accum dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xcen      (xcen),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cov       (cov),
    .busy      (busy)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint field(input int k);
    logic signed [AW-1:0] f;
    f = cov[k*AW +: AW];
    return longint'(f);
  endfunction

  function automatic longint scaled(input longint v);
`ifdef COV_MEAN_SCALE_EN
    return v >>> 7;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int a, input int b, input int c, input int d);
    xcen = {DW'(d), DW'(c), DW'(b), DW'(a)};
  endtask

  task automatic check_cov(input string tag, input vec_t exp);
    for (int k = 0; k < NPAIR; k++) begin
      check($sformatf("%s_k%0d", tag, k), field(k), scaled(exp[k]));
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", longint'(busy), 1);
    check("in_ready_in_accum", longint'(in_ready), 1);
  endtask

  // Feeds n accepted beats of the current xcen; gaps toggles in_valid each cycle.
  task automatic feed(input int n, input bit gaps);
    int beats = 0;
    int cyc = 0;
    int not_ready = 0;
    while (beats < n) begin
      in_valid = !(gaps && cyc[0]);
      if (in_valid && !in_ready) not_ready++;
      tick();
      if (in_valid) beats++;
      cyc++;
    end
    in_valid = 1'b0;
    check("accum_in_ready_held", longint'(not_ready), 0);
  endtask

  // After the final beat: garbage offered while draining, then bounded wait for out_valid.
  task automatic wait_result(input string tag);
    int lat = 0;
    set_x(1000, -1000, 777, 12345);
    in_valid = 1'b1;
    check({tag, "_in_ready_low"}, longint'(in_ready), 0);
    check({tag, "_busy_drain"}, longint'(busy), 1);
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, longint'(lat), 2);
    check({tag, "_out_valid"}, longint'(out_valid), 1);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_dropped"}, longint'(out_valid), 0);
    check({tag, "_busy_idle"}, longint'(busy), 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    xcen      = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_cov0", field(0), 0);
    check("rst_cov9", field(9), 0);

    // Beats offered while idle must be ignored.
    set_x(7, 7, 7, 7);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("idle_ignores_beats", longint'(busy), 0);

    // Frame 1: all ones, then a long HOLD with stray starts.
    set_x(1, 1, 1, 1);
    start_frame();
    feed(N_SAMP, 1'b0);
    wait_result("ones");
    check_cov("ones", EXP_ONES);
    begin
      int drops = 0;
      for (int i = 0; i < 10; i++) begin
        start = i[0];
        tick();
        if (!out_valid) drops++;
      end
      start = 1'b0;
      check("hold_out_valid_stable", longint'(drops), 0);
      check_cov("hold_stable", EXP_ONES);
    end
    // start together with out_ready: handshake wins, start is dropped.
    start = 1'b1;
    handshake("ones");
    start = 1'b0;
    check("hold_start_ignored_in_ready", longint'(in_ready), 0);
    check("idle_keeps_cov", field(4), scaled(128));

    // Frame 2: mixed signs with in_valid gaps and start held high throughout.
    set_x(3, -2, 0, 5);
    start_frame();
    start = 1'b1;
    feed(N_SAMP, 1'b1);
    start = 1'b0;
    wait_result("mix");
    check_cov("mix", EXP_MIX);
    handshake("mix");

    // Frame 3: most negative sample on every channel.
    set_x(-33554432, -33554432, -33554432, -33554432);
    start_frame();
    feed(N_SAMP, 1'b0);
    wait_result("ext");
    check_cov("ext", EXP_EXT);
    handshake("ext");

    // Frame 4: reset after 60 beats, then a clean frame.
    set_x(9, 9, 9, 9);
    start_frame();
    feed(60, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_in_ready", longint'(in_ready), 0);
    check("midrst_cov0", field(0), 0);
    check("midrst_cov9", field(9), 0);
    rst = 1'b0;
    tick();
    check("post_rst_idle", longint'(out_valid), 0);
    set_x(1, 2, 3, 4);
    start_frame();
    feed(N_SAMP, 1'b0);
    wait_result("r1234");
    check_cov("r1234", EXP_1234);
    handshake("r1234");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cov_accum.md
Name: cov_accum

Overview:
- Parametrised covariance accumulator for the whitening stage.
- Takes N_CH centred sample channels per beat and forms every upper-triangle product x_i*x_j (i<=j).
- Accumulates the products over a frame of N_SAMP accepted samples, then presents the summed covariance matrix with a valid/ready handshake.
- Sits between the centring block and the eigen/whitening-matrix computation.

Parameters:
- N_CH, 4, number of input channels (2..8).
- DW, 26, signed width of each centred sample.
- N_SAMP, 128, samples accumulated per frame (>=2).
- CW, $clog2(N_SAMP+1), sample-counter width (derived, localparam).
- NPAIR, N_CH*(N_CH+1)/2, number of upper-triangle pairs (derived, localparam).
- AW, 2*DW+$clog2(N_SAMP), signed accumulator width (derived, localparam).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- in_valid  in  1  sample beat valid.
- in_ready  out  1  block accepts a sample this cycle.
- xcen  in  N_CH*DW  packed signed samples; channel c is at bits [c*DW +: DW].
- out_valid  out  1  cov holds a completed frame.
- out_ready  in  1  downstream accepts cov.
- cov  out  NPAIR*AW  packed signed sums; pair k is at bits [k*AW +: AW].
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: single clock clk; reset rst is synchronous and active-high.
  - Reset forces IDLE, counter=0, pipeline valid=0, all accumulators=0.
  - Outputs after reset: in_ready=0, out_valid=0, cov=0, busy=0.
- Pair order is row-major upper triangle: (0,0),(0,1)..(0,N-1),(1,1)..(N-1,N-1). For N_CH=4: k=0 X1X1, 1 X1X2, 2 X1X3, 3 X1X4, 4 X2X2, 5 X2X3, 6 X2X4, 7 X3X3, 8 X3X4, 9 X4X4.
- Pipeline:
  - Stage 1 registers all NPAIR full-precision signed products (2*DW bits) plus a valid bit.
  - Stage 2 adds each product, sign-extended to AW, into its accumulator.
- FSM states:
  - IDLE: in_ready=0. start -> clear accumulators, counter=0, go to ACCUM.
  - ACCUM: in_ready=1. A beat is accepted when in_valid&in_ready; each accepted beat increments the counter. On the beat that makes counter==N_SAMP, go to DRAIN; in_ready drops the next cycle.
  - DRAIN: in_ready=0. Waits until the stage-1 valid bit is clear (last product added), then asserts out_valid and goes to HOLD. DRAIN lasts 2 cycles.
  - HOLD: out_valid=1, cov stable. out_ready -> out_valid=0, go to IDLE.
- Latency: the last accepted sample causes out_valid exactly 2 cycles later (visible at edge +3).
- Arithmetic:
  - AW is sized so N_SAMP worst-case products cannot overflow; no saturation is needed.
  - The extreme case (-2^(DW-1))^2 must be exact.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle as out_ready in HOLD: handshake completes and the block returns to IDLE; start is ignored.
  - in_valid with in_ready=0: ignored, nothing counted.
  - Gaps in in_valid during ACCUM: the frame stalls; there is no timeout.
  - rst mid-frame: partial sums are discarded immediately and out_valid is not raised.
  - cov keeps the last frame's sums from HOLD through IDLE until the next start clears the accumulators.

Optional Feature:
- Macro: COV_MEAN_SCALE_EN.
- Defined:
  - Each cov field is the accumulator arithmetically right-shifted by $clog2(N_SAMP), i.e. the mean product, still sign-extended to AW.
  - Elaboration fails if N_SAMP is not a power of two.
- Undefined: cov carries the raw sums.
- Handshake and latency are identical in both builds.

Decomposition:
- Package cov_pkg holds:
  - state enum typedef {IDLE, ACCUM, DRAIN, HOLD};
  - function pair_idx(i,j) returning the row-major upper-triangle index;
  - function npair(n).
- One natural sub-module: cov_mac_lane, one per pair via generate. It holds the product register, accumulator, clear and enable, plus the optional shift on its output.

Test Plan:
- Default params, all channels constant 1 for 128 beats -> every cov field = 128; out_valid 2 cycles after the last beat. With COV_MEAN_SCALE_EN, every field = 1.
- x1=3, x2=-2, x3=0, x4=5 for 128 beats -> X1X1=1152, X1X2=-768, X1X3=0, X1X4=1920, X2X2=512, X2X4=-1280, X4X4=3200.
- All channels -2^25 for 128 beats -> each field = 2^57 exactly, with no sign flip (overflow guard).
- in_valid toggled 1/0 each cycle -> result equals the gap-free run; exactly 128 beats counted; in_ready low from the cycle after the 128th beat.
- out_ready held low 10 cycles in HOLD -> out_valid and cov stay stable; start pulses during HOLD are ignored; out_ready=1 -> IDLE next cycle.
- rst asserted after 60 beats -> out_valid, busy and cov all 0 next cycle; a new start then yields a clean frame result.
